// File: rtl/fpro_dbg_pkg.sv
// Shared types and constants for the FPro debug bus master.
// States, command opcodes, response codes and frame lengths.
package fpro_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS_WR,
        BUS_RD,
        RESP
    } state_t;

    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int ADDR_BYTES = 3;
    localparam int DATA_BYTES = 4;

endpackage

// File: rtl/fpro_dbg_bus_master.sv
// Byte-stream debug command to single FPro MMIO read/write transactions.
// Optional inter-byte gap timeout: define FPRO_DBG_TIMEOUT_EN.
module fpro_dbg_bus_master
    import fpro_dbg_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [31:0]       mmio_wr_data,
    input  logic [31:0]       mmio_rd_data,
    output logic              busy
);

    state_t      state;
    logic [1:0]  cnt;
    logic        is_wr;
    logic [31:0] resp;
    logic [2:0]  len;
    logic        accept;
    logic        timeout;

    assign accept  = rx_valid & rx_ready;
    assign tx_data = resp[31:24];
    assign busy    = (state != IDLE);

`ifdef FPRO_DBG_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYC);

    logic [GAP_W-1:0] gap;
    logic             in_frame;

    assign in_frame = (state == ADDR) || (state == DATA);
    assign timeout  = in_frame && !accept &&
                      (gap == GAP_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap <= '0;
        end else if (accept || !in_frame) begin
            gap <= '0;
        end else if (!timeout) begin
            gap <= gap + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_wr        <= 1'b0;
            resp         <= '0;
            len          <= '0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            rx_ready     <= 1'b0;
            tx_valid     <= 1'b0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        if (rx_data == OP_RD || rx_data == OP_WR) begin
                            is_wr <= (rx_data == OP_WR);
                            cnt   <= '0;
                            state <= ADDR;
                        end else begin
                            resp     <= {RSP_NAK, 24'h0};
                            len      <= 3'd1;
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (accept) begin
                        // Upper address bits fall off the top of the shifter.
                        mmio_addr <= {mmio_addr[ADDR_W-9:0], rx_data};
                        cnt       <= cnt + 1'b1;
                        if (cnt == 2'(ADDR_BYTES - 1)) begin
                            cnt <= '0;
                            if (is_wr) begin
                                state <= DATA;
                            end else begin
                                rx_ready <= 1'b0;
                                mmio_cs  <= 1'b1;
                                mmio_rd  <= 1'b1;
                                state    <= BUS_RD;
                            end
                        end
                    end else if (timeout) begin
                        resp     <= {RSP_NAK, 24'h0};
                        len      <= 3'd1;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                DATA: begin
                    if (accept) begin
                        mmio_wr_data <= {mmio_wr_data[23:0], rx_data};
                        cnt          <= cnt + 1'b1;
                        if (cnt == 2'(DATA_BYTES - 1)) begin
                            cnt      <= '0;
                            rx_ready <= 1'b0;
                            mmio_cs  <= 1'b1;
                            mmio_wr  <= 1'b1;
                            state    <= BUS_WR;
                        end
                    end else if (timeout) begin
                        resp     <= {RSP_NAK, 24'h0};
                        len      <= 3'd1;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                BUS_WR: begin
                    mmio_cs  <= 1'b0;
                    mmio_wr  <= 1'b0;
                    resp     <= {RSP_ACK, 24'h0};
                    len      <= 3'd1;
                    tx_valid <= 1'b1;
                    state    <= RESP;
                end
                BUS_RD: begin
                    // Slot mux data is sampled on the edge closing the strobe.
                    mmio_cs  <= 1'b0;
                    mmio_rd  <= 1'b0;
                    resp     <= mmio_rd_data;
                    len      <= 3'd4;
                    tx_valid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (tx_valid && tx_ready) begin
                        resp <= {resp[23:0], 8'h00};
                        len  <= len - 1'b1;
                        if (len == 3'd1) begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    rx_ready <= 1'b0;
                    tx_valid <= 1'b0;
                    mmio_cs  <= 1'b0;
                    mmio_wr  <= 1'b0;
                    mmio_rd  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpro_dbg_bus_master.md
Name: fpro_dbg_bus_master

Overview:
- Debug bus initiator: converts a byte-stream command protocol into single FPro MMIO read and write transactions.
- Returns the results as bytes.
- Sits between a UART byte receiver/transmitter pair and the mmio_* master side of the MMIO system.
- Lets a host peek and poke any slot register without the processor.

Parameters:
- ADDR_W, 21, MMIO address width driven on mmio_addr.
- TIMEOUT_CYC, 1_000_000, inter-byte gap limit in clk cycles; used only with FPRO_DBG_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx_data  input  8  command byte from UART receiver
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  master accepts rx_data this cycle
- tx_data  output  8  response byte to UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts tx_data
- mmio_cs  output  1  bus chip select
- mmio_wr  output  1  bus write strobe
- mmio_rd  output  1  bus read strobe
- mmio_addr  output  ADDR_W  bus word address
- mmio_wr_data  output  32  bus write data
- mmio_rd_data  input  32  bus read data (combinational from slot mux)
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Handshakes:
  - A byte transfers on any clk edge with rx_valid & rx_ready, or with tx_valid & tx_ready.
  - tx_data and tx_valid are held stable until accepted.
- Frames:
  - Write: 0x57, A2, A1, A0, D3, D2, D1, D0 (big-endian).
  - Read: 0x52, A2, A1, A0.
  - Address = {A2,A1,A0}[ADDR_W-1:0]; bits 23..21 are ignored.
- Responses:
  - Write: one byte 0x06 (ACK).
  - Read: D3, D2, D1, D0 of the captured word.
  - Unknown opcode: one byte 0x15 (NAK).
- FSM states: IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP.
  - IDLE: rx_ready=1.
    - 0x52 or 0x57 -> ADDR with byte count 0.
    - Any other byte -> RESP, loading NAK, length 1.
  - ADDR: rx_ready=1. Shifts in 3 bytes. After the third: write -> DATA, read -> BUS_RD.
  - DATA: rx_ready=1. Shifts in 4 bytes. After the fourth -> BUS_WR.
  - BUS_WR: exactly one cycle of mmio_cs=1, mmio_wr=1 with addr and data valid. Next state RESP, loading ACK, length 1.
  - BUS_RD: exactly one cycle of mmio_cs=1, mmio_rd=1. mmio_rd_data is captured into the response shift register on the closing edge. Next state RESP, length 4, MSB first.
  - RESP: rx_ready=0, tx_valid=1. Advances on each accepted byte. After the last byte -> IDLE.
- Bus timing:
  - mmio_cs, mmio_wr and mmio_rd are registered and never asserted outside BUS_WR/BUS_RD.
  - mmio_wr and mmio_rd are never high together.
  - mmio_addr and mmio_wr_data stay stable from the bus cycle until the next frame's loading begins.
- Latency: last command byte accepted -> bus strobe on the next cycle -> tx_valid on the cycle after.
- Back-to-back frames: rx_ready returns in the same cycle the FSM re-enters IDLE. No dead cycle is required beyond that.
- rx_valid while rx_ready=0 (RESP/BUS states): the byte is not consumed. The upstream side holds it.
- Reset:
  - Asynchronous assertion forces IDLE immediately and aborts any partial frame or response.
  - All outputs reset to 0: rx_ready=0 during reset, becoming 1 on the first cycle after release; tx_valid=0, mmio_*=0, busy=0.
  - Counters and shift registers clear to 0.

Optional Feature:
- Macro: FPRO_DBG_TIMEOUT_EN.
- Defined:
  - A gap counter runs in ADDR and DATA and resets on each accepted byte.
  - Reaching TIMEOUT_CYC-1 aborts the frame: no bus cycle is issued; go to RESP with NAK 0x15.
  - The counter is also cleared on entry to IDLE.
- Undefined:
  - No counter is present; a partial frame waits indefinitely.
  - TIMEOUT_CYC is ignored.

Decomposition:
- Package fpro_dbg_pkg holds:
  - the state enum (IDLE..RESP);
  - constants OP_RD=8'h52, OP_WR=8'h57, RSP_ACK=8'h06, RSP_NAK=8'h15;
  - the frame length constants (3 address bytes, 4 data bytes).
- No sub-module. Shift registers and counters stay inline in one module.

Test Plan:
- Write 0x57,0x00,0x00,0x84,0xDE,0xAD,0xBE,0xEF with tx_ready=1 -> one cycle of cs=wr=1, addr=0x000084, wr_data=0xDEADBEEF; then tx byte 0x06; busy drops.
- Read 0x52,0x00,0x00,0xC0 with a bus model returning 0x12345678 -> one cycle of cs=rd=1, addr=0x0000C0; tx bytes 0x12,0x34,0x56,0x78 in order; rd_data changes after the strobe have no effect.
- Opcode 0x41 -> no bus strobe; tx 0x15; the next valid read frame is processed normally.
- Response backpressure: read with tx_ready low for 10 cycles between bytes -> tx_data stable while tx_valid&!tx_ready; rx_ready=0 throughout RESP; all 4 bytes delivered.
- Reset asserted after the 5th write byte -> outputs 0 asynchronously; no mmio_wr ever pulses; after release, a full write frame succeeds.
- With FPRO_DBG_TIMEOUT_EN and TIMEOUT_CYC=100: send 0x57,0x00 then idle 100 cycles -> tx 0x15, no bus strobe, back in IDLE. Without the macro: no response and busy stays 1.
